// File: rtl/fe2de_iq_if.sv
// Fetch-to-decode instruction queue bus: fetch push side and decode head side.
// Handshake: fetch transfers an entry on any edge where fe_valid=1 and iq_full=0
// (and no iq_flush); decode consumes the head on any edge where de_valid=1 and de_stall=0.
interface fe2de_iq_if #(
  parameter int AW = 2
);
  logic          fe_valid;
  logic [31:0]   fetch_pc;
  logic [31:0]   rv32_instr_todec;
  logic [15:0]   rv16_instr_todec;
  logic          fe2de_rv16;
  logic          predict_bxxtaken;
  logic          iq_flush;
  logic          de_stall;
  logic          iq_full;
  logic [AW:0]   iq_count;
  logic          de_valid;
  logic [31:0]   de_pc;
  logic [31:0]   de_instr;
  logic          de_rv16;
  logic          de_predict_taken;

  modport master (
    output fe_valid, fetch_pc, rv32_instr_todec, rv16_instr_todec, fe2de_rv16,
           predict_bxxtaken, iq_flush, de_stall,
    input  iq_full, iq_count, de_valid, de_pc, de_instr, de_rv16, de_predict_taken
  );

  modport slave (
    input  fe_valid, fetch_pc, rv32_instr_todec, rv16_instr_todec, fe2de_rv16,
           predict_bxxtaken, iq_flush, de_stall,
    output iq_full, iq_count, de_valid, de_pc, de_instr, de_rv16, de_predict_taken
  );
endinterface

// File: rtl/fe2de_iq.sv
// Circular instruction queue between fetch and decode; head entry is presented
// combinationally from storage, forced to zero whenever the queue is empty.
module fe2de_iq #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        cpurst,
  fe2de_iq_if.slave   bus
);
  localparam logic [AW:0] full_cnt = (AW+1)'(DEPTH);

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          rv16_mem  [DEPTH];
  logic          pt_mem    [DEPTH];

  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   count;
  logic          full;
  logic          valid;
  logic          push;
  logic          pop;
  logic [31:0]   instr_in;

  assign full     = (count == full_cnt);
  assign valid    = (count != '0);
  // Full is taken from the current count only, so a same-cycle pop never frees a slot.
  assign push     = bus.fe_valid & ~full & ~bus.iq_flush;
  assign pop      = valid & ~bus.de_stall & ~bus.iq_flush;
  assign instr_in = bus.fe2de_rv16 ? {16'h0000, bus.rv16_instr_todec} : bus.rv32_instr_todec;

  always_ff @(posedge clk or posedge cpurst) begin
    if (cpurst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (bus.iq_flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset; the output gating hides its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr]    <= bus.fetch_pc;
      instr_mem[wptr] <= instr_in;
      rv16_mem[wptr]  <= bus.fe2de_rv16;
      pt_mem[wptr]    <= bus.predict_bxxtaken;
    end
  end

  assign bus.iq_full          = full;
  assign bus.iq_count         = count;
  assign bus.de_valid         = valid;
  assign bus.de_pc            = valid ? pc_mem[rptr]    : 32'h0;
  assign bus.de_instr         = valid ? instr_mem[rptr] : 32'h0;
  assign bus.de_rv16          = valid ? rv16_mem[rptr]  : 1'b0;
  assign bus.de_predict_taken = valid ? pt_mem[rptr]    : 1'b0;
endmodule

// File: tb/tb_fe2de_iq.sv
// Directed bench for fe2de_iq: queue-based reference model checked every cycle
// plus hand-computed literal expectations at key points of the sequence.
module tb_fe2de_iq;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int W     = 66;

  logic clk;
  logic cpurst;
  int   n_total;
  int   n_pass;

  fe2de_iq_if #(.AW(AW)) bus ();

  fe2de_iq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk    (clk),
    .cpurst (cpurst),
    .bus    (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: entries packed as {pc, instr, rv16, ptaken}
  logic [W-1:0] exp_q[$];
  bit           m_push;
  bit           m_pop;
  logic [31:0]  m_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req)
      $display("FAIL %s: act=%h req=%h at %0t", name, act, req, $time);
    else
      n_pass++;
  endtask

  // reference model: a FIFO of the accepted entries
  always @(posedge clk or posedge cpurst) begin
    if (cpurst || bus.iq_flush) begin
      exp_q.delete();
    end else begin
      m_push  = bus.fe_valid && (exp_q.size() < DEPTH);
      m_pop   = (exp_q.size() > 0) && !bus.de_stall;
      m_instr = bus.fe2de_rv16 ? {16'h0000, bus.rv16_instr_todec} : bus.rv32_instr_todec;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({bus.fetch_pc, m_instr, bus.fe2de_rv16, bus.predict_bxxtaken});
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    logic [W-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("m_count", 32'(bus.iq_count), 32'(exp_q.size()));
    check("m_full", 32'(bus.iq_full), 32'(exp_q.size() == DEPTH));
    check("m_valid", 32'(bus.de_valid), 32'(exp_q.size() != 0));
    check("m_pc", bus.de_pc, head[65:34]);
    check("m_instr", bus.de_instr, head[33:2]);
    check("m_rv16", 32'(bus.de_rv16), 32'(head[1]));
    check("m_ptaken", 32'(bus.de_predict_taken), 32'(head[0]));
  end

  // driver tasks
  task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] w32,
                     input logic [15:0] w16, input logic is16, input logic pt,
                     input logic fl, input logic st);
    bus.fe_valid         = fv;
    bus.fetch_pc         = pc;
    bus.rv32_instr_todec = w32;
    bus.rv16_instr_todec = w16;
    bus.fe2de_rv16       = is16;
    bus.predict_bxxtaken = pt;
    bus.iq_flush         = fl;
    bus.de_stall         = st;
    @(posedge clk);
    #1;
  endtask

  task automatic push32(input logic [31:0] pc, input logic [31:0] w, input logic st);
    cyc(1'b1, pc, w, 16'hdead, 1'b0, pc[2], 1'b0, st);
  endtask

  task automatic idle(input logic st);
    cyc(1'b0, 32'h0, 32'hffff_ffff, 16'hffff, 1'b0, 1'b0, 1'b0, st);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    cpurst  = 1'b1;
    bus.fe_valid = 1'b0; bus.fetch_pc = '0; bus.rv32_instr_todec = '0;
    bus.rv16_instr_todec = '0; bus.fe2de_rv16 = 1'b0; bus.predict_bxxtaken = 1'b0;
    bus.iq_flush = 1'b0; bus.de_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cpurst = 1'b0;
    check("rst_valid", 32'(bus.de_valid), 32'd0);
    check("rst_count", 32'(bus.iq_count), 32'd0);
    check("rst_full", 32'(bus.iq_full), 32'd0);
    check("rst_pc", bus.de_pc, 32'h0);
    check("rst_instr", bus.de_instr, 32'h0);

    // first push visible one edge later
    push32(32'h100, 32'h0050_0093, 1'b0);
    check("p1_valid", 32'(bus.de_valid), 32'd1);
    check("p1_pc", bus.de_pc, 32'h100);
    check("p1_instr", bus.de_instr, 32'h0050_0093);
    check("p1_count", 32'(bus.iq_count), 32'd1);

    // RVC push while 0x100 is popped, then held under stall
    cyc(1'b1, 32'h104, 32'h1234_5678, 16'h4501, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rvc_instr", bus.de_instr, 32'h0000_4501);
    check("rvc_rv16", 32'(bus.de_rv16), 32'd1);
    check("rvc_pt", 32'(bus.de_predict_taken), 32'd1);
    repeat (3) idle(1'b1);
    check("rvc_hold_pc", bus.de_pc, 32'h104);
    check("rvc_hold_cnt", 32'(bus.iq_count), 32'd1);
    idle(1'b0);
    check("rvc_drain", 32'(bus.de_valid), 32'd0);

    // fill under stall, overflow push ignored, drain in order
    for (int i = 0; i < 4; i++) push32(32'h200 + 32'(4*i), 32'h0010_0013 + 32'(i), 1'b1);
    check("full_flag", 32'(bus.iq_full), 32'd1);
    check("full_count", 32'(bus.iq_count), 32'd4);
    push32(32'h210, 32'hbad0_0000, 1'b1);
    check("ovf_count", 32'(bus.iq_count), 32'd4);
    check("ovf_head", bus.de_pc, 32'h200);
    idle(1'b0);
    check("drain1_full", 32'(bus.iq_full), 32'd0);
    check("drain1_pc", bus.de_pc, 32'h204);
    idle(1'b0);
    check("drain2_pc", bus.de_pc, 32'h208);
    idle(1'b0);
    check("drain3_pc", bus.de_pc, 32'h20C);
    idle(1'b0);
    check("drain_empty", 32'(bus.iq_count), 32'd0);

    // simultaneous push and pop at count 2
    push32(32'h300, 32'h0020_0013, 1'b1);
    push32(32'h304, 32'h0030_0013, 1'b1);
    push32(32'h308, 32'h0040_0013, 1'b0);
    check("pp_count", 32'(bus.iq_count), 32'd2);
    check("pp_head", bus.de_pc, 32'h304);

    // flush at count 3 beats a concurrent push
    push32(32'h30C, 32'h0050_0013, 1'b1);
    check("pre_flush_cnt", 32'(bus.iq_count), 32'd3);
    cyc(1'b1, 32'h500, 32'h0060_0013, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fl_count", 32'(bus.iq_count), 32'd0);
    check("fl_valid", 32'(bus.de_valid), 32'd0);
    check("fl_pc", bus.de_pc, 32'h0);
    check("fl_full", 32'(bus.iq_full), 32'd0);
    push32(32'h8000_0000, 32'h3420_2573, 1'b1);
    check("mtvec_pc", bus.de_pc, 32'h8000_0000);
    check("mtvec_cnt", 32'(bus.iq_count), 32'd1);
    idle(1'b0);

    // ten push/pop pairs across the pointer wrap; model checks order each cycle
    push32(32'h600, 32'h0070_0013, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      push32(32'h600 + 32'(4*i), 32'h0070_0013 + 32'(i), 1'b0);
      check("wrap_head", bus.de_pc, 32'h600 + 32'(4*i));
    end
    check("wrap_count", 32'(bus.iq_count), 32'd1);

    // async reset mid-stream
    push32(32'h700, 32'h0080_0013, 1'b1);
    push32(32'h704, 32'h0090_0013, 1'b1);
    #1;
    cpurst = 1'b1;
    #1;
    check("arst_valid", 32'(bus.de_valid), 32'd0);
    check("arst_count", 32'(bus.iq_count), 32'd0);
    check("arst_pc", bus.de_pc, 32'h0);
    idle(1'b0);
    cpurst = 1'b0;
    push32(32'h900, 32'h00a0_0013, 1'b0);
    check("post_rst_pc", bus.de_pc, 32'h900);
    idle(1'b0);
    idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
